// File: rtl/data_bus_responder.sv
// Bridges the core's stalling data port onto a request/grant/response memory bus,
// one outstanding transaction at a time, with a read timeout and stale-response drain.
module data_bus_responder #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        stall,
    output logic        bus_req,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic [1:0]  state_dbg
);

    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          drain, drain_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          req_n;
    logic [3:0]    we_n;
    logic [31:0]   addr_n, wdata_n, rdata_n;
    logic          err_n;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^ram_addr[1:0];
    assign state_dbg        = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            bus_req       <= 1'b0;
            bus_we        <= 4'd0;
            bus_addr      <= 32'd0;
            bus_wdata     <= 32'd0;
            ram_read_data <= 32'd0;
            bus_err       <= 1'b0;
            drain         <= 1'b0;
            cnt           <= '0;
        end else begin
            state         <= state_n;
            bus_req       <= req_n;
            bus_we        <= we_n;
            bus_addr      <= addr_n;
            bus_wdata     <= wdata_n;
            ram_read_data <= rdata_n;
            bus_err       <= err_n;
            drain         <= drain_n;
            cnt           <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = bus_req;
        we_n    = bus_we;
        addr_n  = bus_addr;
        wdata_n = bus_wdata;
        rdata_n = ram_read_data;
        err_n   = bus_err;
        drain_n = drain;
        cnt_n   = cnt;
        stall   = 1'b0;

        // The response owed to an aborted read is swallowed wherever it shows up.
        if (drain && bus_rvalid) begin
            drain_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                stall = ram_en;
                if (ram_en) begin
                    we_n    = ram_write_en;
                    addr_n  = {ram_addr[31:2], 2'b00};
                    wdata_n = ram_write_data;
                    req_n   = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (bus_gnt) begin
                    req_n   = 1'b0;
                    cnt_n   = CW'(1);
                    state_n = (bus_we != 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                // A live response beats a timeout landing in the same cycle.
                if (bus_rvalid && !drain) begin
                    rdata_n = bus_rdata;
                    state_n = S_DONE;
                end else if (cnt == TIMEOUT_C) begin
                    rdata_n = ERR_DATA;
                    err_n   = 1'b1;
                    drain_n = 1'b1;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed and randomized checks of data_bus_responder against a transaction-level
// model of the core/bus handshake, including timeout, drain and reset abort.
module tb_data_bus_responder;

    localparam int TO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        stall;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        stale_pending;

    data_bus_responder #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk),
        .rst(rst),
        .ram_en(ram_en),
        .ram_write_en(ram_write_en),
        .ram_addr(ram_addr),
        .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data),
        .stall(stall),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata),
        .bus_err(bus_err),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One non-accessing core cycle, optionally carrying a bus response.
    task automatic idle_cycle(input logic rv, input logic [31:0] data);
        ram_en     = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = rv;
        bus_rdata  = data;
        @(negedge clk);
        check("idle_stall", stall, 1'b0);
        check("idle_req", bus_req, 1'b0);
        check("idle_rdata", ram_read_data, exp_rdata);
        next_cycle();
        bus_rvalid = 1'b0;
        if (rv) stale_pending = 1'b0;
    endtask

    // Full core access: gnt after gnt_delay REQ cycles; read response after rv
    // WAIT cycles (rv >= TO means no response, i.e. a timeout).
    task automatic access(input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gnt_delay,
                          input int rv, input logic [31:0] rdata);
        logic [31:0] aligned;
        aligned = {addr[31:2], 2'b00};
        if (stale_pending && we == 4'd0 && rv < 1) rv = 1;

        ram_en         = 1'b1;
        ram_write_en   = we;
        ram_addr       = addr;
        ram_write_data = wdata;
        bus_gnt        = 1'b0;
        bus_rvalid     = 1'b0;
        if (stale_pending && we != 4'd0) begin
            bus_rvalid    = 1'b1;
            bus_rdata     = $urandom;
            stale_pending = 1'b0;
        end
        @(negedge clk);
        check("c0_stall", stall, 1'b1);
        check("c0_no_req", bus_req, 1'b0);
        next_cycle();
        bus_rvalid = 1'b0;

        for (int i = 0; i <= gnt_delay; i++) begin
            bus_gnt = (i == gnt_delay);
            @(negedge clk);
            check("req_valid", bus_req, 1'b1);
            check("req_addr", bus_addr, aligned);
            check("req_we", {28'd0, bus_we}, {28'd0, we});
            check("req_wdata", bus_wdata, wdata);
            check("req_stall", stall, 1'b1);
            next_cycle();
        end
        bus_gnt = 1'b0;

        if (we == 4'd0) begin
            for (int j = 0; j < TO; j++) begin
                bus_rvalid = 1'b0;
                if (j == 0 && stale_pending) begin
                    bus_rvalid    = 1'b1;
                    bus_rdata     = $urandom;
                    stale_pending = 1'b0;
                end else if (j == rv) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata;
                end
                @(negedge clk);
                check("wait_stall", stall, 1'b1);
                check("wait_req", bus_req, 1'b0);
                next_cycle();
                if (j == rv) break;
            end
            bus_rvalid = 1'b0;
            if (rv < TO) begin
                exp_rdata = rdata;
            end else begin
                exp_rdata     = ERR;
                exp_err       = 1'b1;
                stale_pending = 1'b1;
            end
        end

        // Completion cycle: ram_en is still high and must not reissue the access.
        @(negedge clk);
        check("done_stall", stall, 1'b0);
        check("done_rdata", ram_read_data, exp_rdata);
        check("done_err", bus_err, exp_err);
        check("done_req", bus_req, 1'b0);
        next_cycle();
        ram_en = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        ram_en         = 1'b0;
        ram_write_en   = 4'd0;
        ram_addr       = 32'd0;
        ram_write_data = 32'd0;
        bus_gnt        = 1'b0;
        bus_rvalid     = 1'b0;
        bus_rdata      = 32'd0;
        exp_rdata      = 32'd0;
        exp_err        = 1'b0;
        stale_pending  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_stall", stall, 1'b0);
        check("rst_req", bus_req, 1'b0);
        check("rst_we", {28'd0, bus_we}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", ram_read_data, 32'd0);
        check("rst_err", bus_err, 1'b0);
        next_cycle();
        rst = 1'b1;
        idle_cycle(1'b0, 32'd0);

        // Single best-case read of an unaligned address.
        access(4'b0000, 32'h0000_1006, 32'd0, 0, 0, 32'hCAFEF00D);
        idle_cycle(1'b0, 32'd0);

        // Store held off by five withheld grants; read data must not move.
        access(4'b0011, 32'h0000_2000, 32'h1234_5678, 5, 0, 32'd0);
        idle_cycle(1'b0, 32'd0);

        // Back-to-back read then write with one unstalled cycle between.
        access(4'b0000, 32'h0000_3008, 32'd0, 0, 1, 32'hA5A5_0001);
        access(4'b1111, 32'h0000_300C, 32'h0BAD_F00D, 1, 0, 32'd0);

        // Response in the very cycle the timeout would fire.
        access(4'b0000, 32'h0000_4000, 32'd0, 0, TO - 1, 32'h7777_1111);
        check("coincide_err", bus_err, 1'b0);
        idle_cycle(1'b0, 32'd0);

        // Randomized mix of reads, writes, grant delays and timeouts.
        for (int k = 0; k < 25; k++) begin
            logic [3:0] we;
            we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            access(we, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 5), $urandom);
            repeat ($urandom_range(0, 2)) idle_cycle(1'b0, 32'd0);
        end
        if (stale_pending) idle_cycle(1'b1, 32'h5555_5555);

        // Timeout, then the late response, then a fresh read that must see 2.
        access(4'b0000, 32'h0000_5000, 32'd0, 0, TO, 32'd0);
        check("to_rdata", ram_read_data, ERR);
        check("to_err", bus_err, 1'b1);
        idle_cycle(1'b1, 32'h0000_0001);
        access(4'b0000, 32'h0000_5004, 32'd0, 0, 0, 32'h0000_0002);
        check("after_drain_rdata", ram_read_data, 32'h0000_0002);
        idle_cycle(1'b0, 32'd0);

        // Reset asserted in the first WAIT cycle of a read.
        ram_en       = 1'b1;
        ram_write_en = 4'd0;
        ram_addr     = 32'h0000_0040;
        next_cycle();
        bus_gnt = 1'b1;
        next_cycle();
        bus_gnt = 1'b0;
        #2;
        rst    = 1'b0;
        ram_en = 1'b0;
        @(negedge clk);
        check("midrst_state", {30'd0, state_dbg}, 32'd0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_req", bus_req, 1'b0);
        check("midrst_rdata", ram_read_data, 32'd0);
        check("midrst_err", bus_err, 1'b0);
        next_cycle();
        rst           = 1'b1;
        exp_rdata     = 32'd0;
        exp_err       = 1'b0;
        stale_pending = 1'b0;
        idle_cycle(1'b0, 32'd0);
        access(4'b0000, 32'h0000_6001, 32'd0, 2, 2, 32'h1357_9BDF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
